// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side view of the pipeline sequencing controller: hazard inputs
// and pipeline-register enable/flush controls plus performance counters.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ID_rs1Addr;
  logic [4:0]       ID_rs2Addr;
  logic             ID_useRs1;
  logic             ID_useRs2;
  logic             ID_JAL;
  logic             EX_MemRead;
  logic [4:0]       EX_rdAddr;
  logic             EX_Redirect;
  logic             MEM_Access;
  logic             dmem_ready;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Write;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rs1Addr, ID_rs2Addr, ID_useRs1, ID_useRs2, ID_JAL,
           EX_MemRead, EX_rdAddr, EX_Redirect, MEM_Access, dmem_ready,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs1Addr, ID_rs2Addr, ID_useRs1, ID_useRs2, ID_JAL,
           EX_MemRead, EX_rdAddr, EX_Redirect, MEM_Access, dmem_ready,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, redirect flushes,
// data-memory freeze with watchdog, and stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              load_use, mem_wait, redirect_ev;
  logic              pc_write, ifid_write, ifid_flush, idex_flush, exmem_write;

  assign load_use = hz.EX_MemRead && (hz.EX_rdAddr != 5'd0) &&
                    ((hz.ID_useRs1 && (hz.ID_rs1Addr == hz.EX_rdAddr)) ||
                     (hz.ID_useRs2 && (hz.ID_rs2Addr == hz.EX_rdAddr)));
  assign mem_wait = hz.MEM_Access && !hz.dmem_ready;

  // Entering the wait from RUN counts as the first wait cycle.
  assign wait_inc = (state == RUN) ? WAIT_W'(1) : wait_cnt + WAIT_W'(1);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    redirect_ev = 1'b0;
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    case (state)
      RUN, MWAIT: begin
        if (mem_wait) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_write = 1'b0;
          wait_nxt    = wait_inc;
          state_nxt   = (wait_inc >= WAIT_W'(MEM_TIMEOUT)) ? ERR : MWAIT;
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
          if (hz.EX_Redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            redirect_ev = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (hz.ID_JAL) begin
            ifid_flush = 1'b1;
          end
        end
      end
      ERR: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        exmem_write = 1'b0;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_ev && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.PC_Write    = pc_write;
  assign hz.IFID_Write  = ifid_write;
  assign hz.IFID_Flush  = ifid_flush;
  assign hz.IDEX_Flush  = idex_flush;
  assign hz.EXMEM_Write = exmem_write;
  assign hz.mem_timeout = (state == ERR);
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short watchdog and 4-bit counters.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write}
  localparam logic [4:0] C_RUN    = 5'b11001;
  localparam logic [4:0] C_BUBBLE = 5'b00011;
  localparam logic [4:0] C_REDIR  = 5'b11111;
  localparam logic [4:0] C_JAL    = 5'b11101;
  localparam logic [4:0] C_FREEZE = 5'b00000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    #1;
    check(tag, {11'd0, hz.PC_Write, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Flush, hz.EXMEM_Write},
          {11'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.ID_rs1Addr  = 5'd0;
    hz.ID_rs2Addr  = 5'd0;
    hz.ID_useRs1   = 1'b0;
    hz.ID_useRs2   = 1'b0;
    hz.ID_JAL      = 1'b0;
    hz.EX_MemRead  = 1'b0;
    hz.EX_rdAddr   = 5'd0;
    hz.EX_Redirect = 1'b0;
    hz.MEM_Access  = 1'b0;
    hz.dmem_ready  = 1'b1;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd);
    hz.EX_MemRead = 1'b1;
    hz.EX_rdAddr  = rd;
    hz.ID_useRs1  = 1'b1;
    hz.ID_rs1Addr = rd;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk_ctrl("reset_ctrl", C_RUN);
    check("reset_timeout", {15'd0, hz.mem_timeout}, 16'd0);
    check("reset_stall", {12'd0, hz.stall_cnt}, 16'd0);
    check("reset_flush", {12'd0, hz.flush_cnt}, 16'd0);

    // Load-use on rs1
    load_use_rs1(5'd5);
    chk_ctrl("lu_bubble", C_BUBBLE);
    cyc();
    idle();
    chk_ctrl("lu_after", C_RUN);
    check("lu_stall", {12'd0, hz.stall_cnt}, 16'd1);

    // Load-use on rs2
    hz.EX_MemRead = 1'b1;
    hz.EX_rdAddr  = 5'd9;
    hz.ID_useRs2  = 1'b1;
    hz.ID_rs2Addr = 5'd9;
    hz.ID_useRs1  = 1'b1;
    hz.ID_rs1Addr = 5'd3;
    chk_ctrl("lu_rs2_bubble", C_BUBBLE);
    cyc();
    idle();
    check("lu_rs2_stall", {12'd0, hz.stall_cnt}, 16'd2);

    // x0 destination never stalls
    load_use_rs1(5'd0);
    chk_ctrl("x0_no_stall", C_RUN);
    cyc();
    idle();
    check("x0_stall", {12'd0, hz.stall_cnt}, 16'd2);

    // Redirect beats load-use
    load_use_rs1(5'd5);
    hz.EX_Redirect = 1'b1;
    hz.ID_JAL      = 1'b1;
    chk_ctrl("redir_lu", C_REDIR);
    cyc();
    idle();
    check("redir_flush", {12'd0, hz.flush_cnt}, 16'd1);
    check("redir_stall", {12'd0, hz.stall_cnt}, 16'd2);

    // JAL in ID
    hz.ID_JAL = 1'b1;
    chk_ctrl("jal", C_JAL);
    cyc();
    idle();
    check("jal_flush", {12'd0, hz.flush_cnt}, 16'd1);

    // 3-cycle memory wait with a pending redirect held through the freeze
    hz.MEM_Access  = 1'b1;
    hz.dmem_ready  = 1'b0;
    hz.EX_Redirect = 1'b1;
    chk_ctrl("mw_freeze1", C_FREEZE);
    cyc();
    chk_ctrl("mw_freeze2", C_FREEZE);
    cyc();
    chk_ctrl("mw_freeze3", C_FREEZE);
    check("mw_flush_held", {12'd0, hz.flush_cnt}, 16'd1);
    cyc();
    hz.dmem_ready = 1'b1;
    chk_ctrl("mw_release_redir", C_REDIR);
    check("mw_stall", {12'd0, hz.stall_cnt}, 16'd5);
    check("mw_no_timeout", {15'd0, hz.mem_timeout}, 16'd0);
    cyc();
    idle();
    chk_ctrl("mw_run", C_RUN);
    check("mw_flush", {12'd0, hz.flush_cnt}, 16'd2);
    check("mw_stall_after", {12'd0, hz.stall_cnt}, 16'd5);

    // Watchdog: 4 consecutive wait cycles -> ERR
    hz.MEM_Access = 1'b1;
    hz.dmem_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    chk_ctrl("to_4th_freeze", C_FREEZE);
    check("to_not_yet", {15'd0, hz.mem_timeout}, 16'd0);
    cyc();
    idle();
    chk_ctrl("err_ctrl", C_FREEZE);
    check("err_timeout", {15'd0, hz.mem_timeout}, 16'd1);
    check("err_stall", {12'd0, hz.stall_cnt}, 16'd9);
    cyc();
    cyc();
    check("err_sticky", {15'd0, hz.mem_timeout}, 16'd1);
    check("err_stall_cnt", {12'd0, hz.stall_cnt}, 16'd11);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_ctrl("err_reset_ctrl", C_RUN);
    check("err_reset_to", {15'd0, hz.mem_timeout}, 16'd0);
    check("err_reset_stall", {12'd0, hz.stall_cnt}, 16'd0);
    check("err_reset_flush", {12'd0, hz.flush_cnt}, 16'd0);

    // Counter saturation
    load_use_rs1(5'd7);
    for (int i = 0; i < 20; i++) cyc();
    check("sat_stall", {12'd0, hz.stall_cnt}, 16'd15);
    idle();
    hz.EX_Redirect = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    check("sat_flush", {12'd0, hz.flush_cnt}, 16'd15);
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. It sits beside the decode stage and drives the write-enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three conditions:
- load-use hazards, resolved with a one-cycle bubble;
- control redirects from JAL in ID and from taken branches/JALR in EX, resolved by flushing;
- data-memory wait states, resolved with a full freeze and a watchdog timeout.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16, max consecutive dmem wait cycles before entering ERR
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- ID_rs1Addr  in  5  rs1 field of instruction in ID
- ID_rs2Addr  in  5  rs2 field of instruction in ID
- ID_useRs1  in  1  ID instruction reads rs1 (R, I, LW, SW, SB, JALR)
- ID_useRs2  in  1  ID instruction reads rs2 (R, SW, SB)
- ID_JAL  in  1  JAL decoded in ID
- EX_MemRead  in  1  load in EX
- EX_rdAddr  in  5  destination register of EX instruction
- EX_Redirect  in  1  taken branch or JALR resolved in EX
- MEM_Access  in  1  load/store in MEM stage
- dmem_ready  in  1  data memory completes access this cycle
- PC_Write  out  1  PC register enable
- IFID_Write  out  1  IF/ID enable
- IFID_Flush  out  1  IF/ID clear to NOP (takes effect only when IFID_Write=1)
- IDEX_Flush  out  1  ID/EX clear to bubble
- EXMEM_Write  out  1  EX/MEM and MEM/WB enable
- mem_timeout  out  1  sticky error flag, set in ERR
- stall_cnt  out  CNT_W  cycles with PC_Write=0
- flush_cnt  out  CNT_W  redirect events

## Operation
- States: RUN, MWAIT, ERR. State reset value: RUN.
- All control outputs are combinational from the current state and inputs.
- Counters and state are registered.

Definitions:
- load_use = EX_MemRead & (EX_rdAddr≠0) & ((ID_useRs1 & ID_rs1Addr==EX_rdAddr) | (ID_useRs2 & ID_rs2Addr==EX_rdAddr)).
- mem_wait = MEM_Access & ~dmem_ready.

In RUN, conditions are evaluated in priority order; the first match applies:
1. mem_wait: freeze. PC_Write=IFID_Write=EXMEM_Write=0, no flushes. Next state MWAIT, wait counter loads 1.
2. EX_Redirect: PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1. flush_cnt+1. load_use and ID_JAL are ignored.
3. load_use: PC_Write=0, IFID_Write=0, IDEX_Flush=1, EXMEM_Write=1.
4. ID_JAL: IFID_Flush=1, all writes 1.
5. Otherwise: all writes 1, no flushes.

MWAIT:
- Freeze outputs are held (as item 1 above) while mem_wait=1.
- When dmem_ready=1, the outputs for that cycle are evaluated as in RUN items 2–5 and the next state is RUN.
- Wait counter increments every MWAIT cycle. If it reaches MEM_TIMEOUT while still waiting, the next state is ERR.

ERR:
- All writes 0, no flushes, mem_timeout=1.
- Exits only on reset.

Counters:
- stall_cnt increments on every cycle with PC_Write=0, including ERR.
- Both counters saturate at all-ones; they do not wrap.

Reset:
- All outputs are driven from RUN with all-zero counters: mem_timeout=0, stall_cnt=0, flush_cnt=0, wait counter 0.
- Reset during MWAIT or ERR returns to RUN on the next edge.

## Timing
- Flush and stall controls are valid in the same cycle as the triggering inputs; the pipeline registers act on the next rising edge.
- Load-use: exactly one bubble cycle. On the following cycle the load has moved to MEM, so load_use drops.
- Redirect: 0 cycles of controller latency. The ID and IF instructions are squashed on the next edge (2-instruction penalty).
- JAL in ID: 1-instruction penalty.
- Memory wait adds exactly N freeze cycles for N cycles of dmem_ready=0.
- ERR is entered on the edge after the MEM_TIMEOUT-th consecutive wait cycle.
- Simultaneous EX_Redirect and load_use: redirect wins; no bubble; stall_cnt unchanged.
- Simultaneous mem_wait and EX_Redirect: freeze wins. The redirect is re-evaluated when the freeze releases, because the EX inputs are held.

## Test plan
- Load-use: EX_MemRead=1, EX_rdAddr=5, ID_useRs1=1, ID_rs1Addr=5 for one cycle → PC_Write=0, IFID_Write=0, IDEX_Flush=1. Next cycle all writes 1. stall_cnt=1.
- x0 destination: same as above but EX_rdAddr=0 → no stall, stall_cnt stays 0.
- Redirect plus load_use in the same cycle → IFID_Flush=IDEX_Flush=1, PC_Write=1, flush_cnt=1, stall_cnt=0.
- Memory wait: MEM_Access=1, dmem_ready low for 3 cycles then high → 3 frozen cycles (all writes 0), RUN on the 4th cycle, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low → ERR after 4 wait cycles, mem_timeout=1, writes stay 0. Pulsing reset for one cycle → RUN, mem_timeout=0, counters 0.
- Saturation: CNT_W=4, 20 load-use stalls → stall_cnt stays at 15.
